mem_access_queue: RTL and testbench
===================================

# mem_access_queue

Parametrised data-memory access unit for the MIPS pipeline's memory stage. It accepts load and store requests from the pipeline through a valid/ready handshake and issues them on the data bus (`dreq`/`dresp`). Up to `DEPTH` accepted bus requests may be waiting for `data_ok` at the same time. It returns byte-lane-aligned and extended load data, reports alignment exceptions in program order, and handles pipeline flushes.

## Interface
- `DEPTH`, 2: maximum number of requests waiting for `data_ok`; must be a power of two and at least 1.
- `TAG_W`, 4: width of the request tag, which is returned unchanged with the response.
- `clk` input 1: clock.
- `reset` input 1: asynchronous, active-high reset.
- `req_valid` input 1: a request is offered.
- `req_ready` output 1: the request is accepted in this cycle.
- `req_write` input 1: 1 = store, 0 = load.
- `req_addr` input 32: byte address.
- `req_size` input msize_t: `MSIZE1`, `MSIZE2` or `MSIZE4`.
- `req_signed` input 1: sign-extend load data.
- `req_data` input 32: store data, right-aligned.
- `req_tag` input TAG_W: request identifier.
- `flush` input 1: cancel all responses for requests not yet completed.
- `rsp_valid` output 1: one-cycle response pulse; no backpressure.
- `rsp_tag` output TAG_W: tag of the responding request.
- `rsp_data` output 32: extended load data; 0 for stores.
- `rsp_exc` output 1: alignment exception.
- `rsp_exccode` output 5: `EX_ADEL` or `EX_ADES`.
- `rsp_badvaddr` output 32: the faulting address.
- `dreq` output dbus_req_t: data bus request (valid, addr, size, strobe, data).
- `dresp` input dbus_resp_t: data bus response (addr_ok, data_ok, data).

## Operation
- **Issue register.** One entry holding addr, size, write, signed, tag, data, strobe and a kill bit.
  - `dreq.valid` equals the issue register's valid bit.
  - `dreq` fields stay stable until `addr_ok`.
- **Outstanding FIFO.** `DEPTH` entries holding tag, write, size, addr[1:0], signed and kill.
  - `cnt` has width clog2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
- **Aligned request acceptance.** `req_ready` = !issue_valid && cnt < DEPTH. The request is loaded into the issue register.
- **Misaligned request acceptance.** A request is misaligned when size is MSIZE2 and addr[0] = 1, or size is MSIZE4 and addr[1:0] ≠ 0.
  - `req_ready` = !issue_valid && cnt == 0.
  - The request is never issued on the bus.
  - The exception response fires in the next cycle: code `EX_ADES` if write, otherwise `EX_ADEL`.
- **Store lanes.** Data is replicated across the byte lanes. Strobe:
  - MSIZE1: 4'b0001 << addr[1:0].
  - MSIZE2: 4'b0011 << addr[1:0].
  - MSIZE4: 4'b1111.
- **Address acceptance.** On `addr_ok`, the issue register moves into the FIFO tail and the issue register clears.
- **Data completion.** On `data_ok`, the request retires:
  - the FIFO head, if cnt > 0;
  - otherwise the issue-register request that receives `addr_ok` in the same cycle. That request then bypasses the FIFO.
- **Load data.** Shift `dresp.data` right by 8·addr[1:0], mask to the request size, then sign-extend or zero-extend according to `signed`.
- **Flush.**
  - Sets the kill bit on the issue register and on every FIFO entry. A misaligned response due in the next cycle is suppressed.
  - Killed entries still complete their bus transaction unchanged, so a store already accepted is performed.
  - Killed entries produce no `rsp_valid`.
  - A request offered while `flush` = 1 is not accepted (`req_ready` = 0).
- **Simultaneous `addr_ok` and `data_ok` with cnt > 0.** Push and pop happen in the same cycle; cnt is unchanged.
- **Protocol errors.** `data_ok` while cnt == 0 and the issue register is not being accepted is ignored.
- **Reset.** Clears the issue register, the FIFO pointers, cnt and all `rsp_*` outputs. `dreq.valid` = 0 and `req_ready` = 0 during reset.

## Timing
- **Request to bus.** Acceptance happens at edge N; `dreq.valid` is asserted from cycle N+1.
- **Response.** `data_ok` at edge M gives `rsp_valid` in cycle M+1, with all `rsp_*` fields registered.
- **Best case.** `addr_ok` and `data_ok` both arrive in cycle N+1, so the response comes 2 cycles after acceptance.
- **Ordering.** Responses are strictly in acceptance order.
- **Throughput.** One bus request per 2 cycles. The issue register must empty before the next request is accepted.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Alignment checking, the exception path and the `cnt == 0` gating for misaligned requests are compiled in.
- `MEM_ALIGN_CHECK_EN` not defined:
  - There is no check. For MSIZE2, addr[0] is forced to 0; for MSIZE4, addr[1:0] is forced to 0.
  - `rsp_exc`, `rsp_exccode` and `rsp_badvaddr` are tied to 0.

## Test plan
- **Signed byte load.** LB at 0x1003 with `signed` = 1, bus data 0x80AA_BBCC. Expect `dreq.addr` = 0x1003, strobe 0, and a response 2 cycles after acceptance with `rsp_data` = 0xFFFF_FF80.
- **Halfword store.** SH at 0x2002 with data 0x0000_1234. Expect strobe 4'b1100, `dreq.data` = 0x1234_1234, then `rsp_valid` with `rsp_data` = 0.
- **Pipelining with DEPTH = 2.**
  - `addr_ok` is always 1 and `data_ok` is held low for 6 cycles, with 3 load requests offered.
  - Expect 2 requests accepted and `req_ready` = 0 while cnt == 2.
  - When `data_ok` returns, tags come back in order.
- **Misaligned load.** LW at 0x3001 while one load is outstanding. Expect the LW to wait until that load retires, then `rsp_exc` = 1, `EX_ADEL`, badvaddr 0x3001, and no `dreq.valid` for it.
- **Flush.** Flush with 2 outstanding requests. Expect both `data_ok` pulses to be consumed with no `rsp_valid`; a new request afterwards responds normally.
- **Reset mid-operation.** Assert `reset` while in the LOADWAIT-equivalent condition (cnt = 1). Expect `dreq.valid` = 0, cnt = 0 and no response after release.

Source files
------------

// File: rtl/mem_access_queue.sv
// MIPS memory-stage data access unit: one issue register feeding a DEPTH-entry
// outstanding FIFO on the dbus. Alignment checking is compiled in with MEM_ALIGN_CHECK_EN.
`timescale 1ns/1ps

package mem_access_pkg;
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  localparam logic [4:0] EX_ADEL = 5'h04;
  localparam logic [4:0] EX_ADES = 5'h05;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;
endpackage

module mem_access_queue
  import mem_access_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  msize_t           req_size,
  input  logic             req_signed,
  input  logic [31:0]      req_data,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             rsp_valid,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_data,
  output logic             rsp_exc,
  output logic [4:0]       rsp_exccode,
  output logic [31:0]      rsp_badvaddr,
  output dbus_req_t        dreq,
  input  dbus_resp_t       dresp
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // issue register
  logic             iv, iw, isg, ikill;
  logic [31:0]      ia, idata;
  msize_t           isz;
  logic [3:0]       istrb;
  logic [TAG_W-1:0] itag;

  // outstanding FIFO
  logic [TAG_W-1:0] f_tag   [DEPTH];
  logic             f_write [DEPTH];
  logic             f_sign  [DEPTH];
  logic             f_kill  [DEPTH];
  msize_t           f_size  [DEPTH];
  logic [1:0]       f_lo    [DEPTH];
  logic [PW-1:0]    wp, rp;
  logic [CW-1:0]    cnt;

  logic             misaligned, accept, accept_ok;
  logic [31:0]      eff_addr, wdata;
  logic [3:0]       strb;
  logic             addr_acc, pop, bypass, push, done;
  logic             rsp_valid_q;
  logic [TAG_W-1:0] d_tag;
  logic             d_write, d_sign, d_kill;
  msize_t           d_size;
  logic [1:0]       d_lo;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] lo,
                                              input msize_t sz, input logic sg);
    logic [31:0] sh;
    sh = raw >> {lo, 3'b000};
    case (sz)
      MSIZE1:  return {{24{sg & sh[7]}}, sh[7:0]};
      MSIZE2:  return {{16{sg & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  always_comb begin
    eff_addr   = req_addr;
    misaligned = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misaligned = (req_size == MSIZE2 && req_addr[0]) ||
                 (req_size == MSIZE4 && req_addr[1:0] != 2'b00);
`else
    case (req_size)
      MSIZE2:  eff_addr[0]   = 1'b0;
      MSIZE4:  eff_addr[1:0] = 2'b00;
      default: ;
    endcase
`endif
    case (req_size)
      MSIZE1: begin
        strb  = 4'b0001 << eff_addr[1:0];
        wdata = {4{req_data[7:0]}};
      end
      MSIZE2: begin
        strb  = 4'b0011 << eff_addr[1:0];
        wdata = {2{req_data[15:0]}};
      end
      default: begin
        strb  = 4'b1111;
        wdata = req_data;
      end
    endcase
    if (!req_write) strb = '0;
  end

  // Misaligned requests wait for an empty FIFO so their exception stays in program order.
  assign req_ready = !reset && !flush && !iv && (misaligned ? (cnt == '0) : (cnt < FULL));
  assign accept    = req_valid && req_ready;
  assign accept_ok = accept && !misaligned;

  assign addr_acc = iv && dresp.addr_ok;
  assign pop      = dresp.data_ok && (cnt != '0);
  assign bypass   = dresp.data_ok && (cnt == '0) && addr_acc;
  assign push     = addr_acc && !bypass;
  assign done     = pop || bypass;

  always_comb begin
    d_tag   = itag;
    d_write = iw;
    d_size  = isz;
    d_lo    = ia[1:0];
    d_sign  = isg;
    d_kill  = ikill;
    if (cnt != '0) begin
      d_tag   = f_tag[rp];
      d_write = f_write[rp];
      d_size  = f_size[rp];
      d_lo    = f_lo[rp];
      d_sign  = f_sign[rp];
      d_kill  = f_kill[rp];
    end
  end

  always_comb begin
    dreq.valid  = iv;
    dreq.addr   = ia;
    dreq.size   = isz;
    dreq.strobe = istrb;
    dreq.data   = idata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iv    <= 1'b0;
      iw    <= 1'b0;
      isg   <= 1'b0;
      ikill <= 1'b0;
      ia    <= '0;
      idata <= '0;
      isz   <= MSIZE1;
      istrb <= '0;
      itag  <= '0;
    end else begin
      if (flush) ikill <= 1'b1;
      if (addr_acc) iv <= 1'b0;
      if (accept_ok) begin
        iv    <= 1'b1;
        iw    <= req_write;
        isg   <= req_signed;
        ikill <= 1'b0;
        ia    <= eff_addr;
        idata <= wdata;
        isz   <= req_size;
        istrb <= strb;
        itag  <= req_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      f_tag[wp]   <= itag;
      f_write[wp] <= iw;
      f_size[wp]  <= isz;
      f_lo[wp]    <= ia[1:0];
      f_sign[wp]  <= isg;
      f_kill[wp]  <= ikill || flush;
    end
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) f_kill[i] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= ptr_next(wp);
      if (pop)  rp <= ptr_next(rp);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic mis_q;
  logic accept_mis;
  assign accept_mis = accept && misaligned;
  // A flush arriving while a misaligned exception is on the outputs cancels it.
  assign rsp_valid  = rsp_valid_q && !(mis_q && flush);
`else
  assign rsp_valid    = rsp_valid_q;
  assign rsp_exc      = 1'b0;
  assign rsp_exccode  = '0;
  assign rsp_badvaddr = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_tag      <= '0;
      rsp_data     <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      rsp_exc      <= 1'b0;
      rsp_exccode  <= '0;
      rsp_badvaddr <= '0;
      mis_q        <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mis_q       <= 1'b0;
`endif
      if (done) begin
        rsp_valid_q  <= !(d_kill || flush);
        rsp_tag      <= d_tag;
        rsp_data     <= d_write ? '0 : load_extend(dresp.data, d_lo, d_size, d_sign);
`ifdef MEM_ALIGN_CHECK_EN
        rsp_exc      <= 1'b0;
        rsp_exccode  <= '0;
        rsp_badvaddr <= '0;
      end else if (accept_mis) begin
        rsp_valid_q  <= 1'b1;
        mis_q        <= 1'b1;
        rsp_tag      <= req_tag;
        rsp_data     <= '0;
        rsp_exc      <= 1'b1;
        rsp_exccode  <= req_write ? EX_ADES : EX_ADEL;
        rsp_badvaddr <= req_addr;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_access_queue.sv
// Directed bench for mem_access_queue: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares every rsp_valid pulse.
`timescale 1ns/1ps

module tb_mem_access_queue;
  import mem_access_pkg::*;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready, req_write, req_signed, flush;
  logic [31:0]      req_addr, req_data;
  msize_t           req_size;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid, rsp_exc;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_data, rsp_badvaddr;
  logic [4:0]       rsp_exccode;
  dbus_req_t        dreq;
  dbus_resp_t       dresp;

  mem_access_queue #(.DEPTH(2), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_data(req_data), .req_tag(req_tag), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .rsp_exc(rsp_exc), .rsp_exccode(rsp_exccode), .rsp_badvaddr(rsp_badvaddr),
    .dreq(dreq), .dresp(dresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             exc;
    logic [4:0]       code;
    logic [31:0]      badv;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_rsp: got tag=%h data=%h exc=%b, required no response",
                 rsp_tag, rsp_data, rsp_exc);
      end else begin
        e = sb.pop_front();
        if (rsp_tag !== e.tag || rsp_data !== e.data || rsp_exc !== e.exc ||
            rsp_exccode !== e.code || rsp_badvaddr !== e.badv || cyc != e.cyc) begin
          n_err++;
          $display("FAIL rsp_tag_%0h: got tag=%h data=%h exc=%b code=%h bad=%h cyc=%0d, required tag=%h data=%h exc=%b code=%h bad=%h cyc=%0d",
                   e.tag, rsp_tag, rsp_data, rsp_exc, rsp_exccode, rsp_badvaddr, cyc,
                   e.tag, e.data, e.exc, e.code, e.badv, e.cyc);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_rsp(input logic [TAG_W-1:0] t, input logic [31:0] d, input logic x,
                            input logic [4:0] c, input logic [31:0] b, input int at);
    exp_t n;
    n.tag = t; n.data = d; n.exc = x; n.code = c; n.badv = b; n.cyc = at;
    sb.push_back(n);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic a, input logic d, input logic [31:0] x);
    dresp.addr_ok = a;
    dresp.data_ok = d;
    dresp.data    = x;
  endtask

  task automatic set_req(input logic w, input logic [31:0] a, input msize_t s, input logic sg,
                         input logic [31:0] d, input logic [TAG_W-1:0] t);
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = s;
    req_signed = sg; req_data = d; req_tag = t;
  endtask

  // Holds the request until accepted; acc is the cycle count right after the accepting edge.
  task automatic offer(input logic w, input logic [31:0] a, input msize_t s, input logic sg,
                       input logic [31:0] d, input logic [TAG_W-1:0] t, output int acc);
    set_req(w, a, s, sg, d, t);
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (acc < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL offer_timeout_%0h: got no acceptance in 20 cycles, required acceptance", t);
    end
  endtask

  initial begin
    int acc;
    int k;
    logic rdy;

    reset = 1'b1; flush = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = MSIZE1;
    req_signed = 1'b0; req_data = '0; req_tag = '0;
    bus(1'b0, 1'b0, '0);
    step(2);
    check("reset_dreq_valid", dreq.valid, 0);
    check("reset_req_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    reset = 1'b0;
    step();

    // signed byte load at the top lane
    offer(1'b0, 32'h1003, MSIZE1, 1'b1, '0, 4'h1, acc);
    check("lb_dreq_valid", dreq.valid, 1);
    check("lb_dreq_addr", dreq.addr, 32'h1003);
    check("lb_dreq_strobe", dreq.strobe, 0);
    expect_rsp(4'h1, 32'hFFFF_FF80, 1'b0, '0, '0, acc + 1);
    bus(1'b1, 1'b1, 32'h80AA_BBCC);
    step();
    bus(1'b0, 1'b0, '0);
    step();

    // halfword store, upper lanes
    offer(1'b1, 32'h2002, MSIZE2, 1'b0, 32'h0000_1234, 4'h2, acc);
    check("sh_dreq_strobe", dreq.strobe, 4'b1100);
    check("sh_dreq_data", dreq.data, 32'h1234_1234);
    expect_rsp(4'h2, 32'h0, 1'b0, '0, '0, acc + 1);
    bus(1'b1, 1'b1, 32'hDEAD_BEEF);
    step();
    bus(1'b0, 1'b0, '0);
    step();

    // byte store at lane 1
    offer(1'b1, 32'h2001, MSIZE1, 1'b0, 32'h0000_00AB, 4'h3, acc);
    check("sb_dreq_strobe", dreq.strobe, 4'b0010);
    check("sb_dreq_data", dreq.data, 32'hABAB_ABAB);
    expect_rsp(4'h3, 32'h0, 1'b0, '0, '0, acc + 1);
    bus(1'b1, 1'b1, 32'h0);
    step();
    bus(1'b0, 1'b0, '0);
    step();

    // pipelining: addr_ok always high, data_ok held low for 6 cycles, 3 loads offered
    bus(1'b1, 1'b0, '0);
    k = 0;
    set_req(1'b0, 32'h4000, MSIZE4, 1'b0, '0, 4'h4);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rdy = req_ready && req_valid;
      @(posedge clk);
      #1;
      if (rdy) begin
        k++;
        if (k == 1) set_req(1'b0, 32'h4004, MSIZE4, 1'b0, '0, 4'h5);
        else if (k == 2) set_req(1'b0, 32'h4008, MSIZE4, 1'b0, '0, 4'h6);
        else req_valid = 1'b0;
      end
    end
    check("pipe_accepted", k, 2);
    check("pipe_ready_full", req_ready, 0);
    req_valid = 1'b0;
    expect_rsp(4'h4, 32'h1111_1111, 1'b0, '0, '0, cyc + 1);
    bus(1'b1, 1'b1, 32'h1111_1111);
    step();
    expect_rsp(4'h5, 32'h2222_2222, 1'b0, '0, '0, cyc + 1);
    bus(1'b1, 1'b1, 32'h2222_2222);
    step();
    bus(1'b0, 1'b0, '0);
    step(2);

`ifdef MEM_ALIGN_CHECK_EN
    // misaligned LW waits behind an outstanding load, then raises ADEL
    bus(1'b1, 1'b0, '0);
    offer(1'b0, 32'h3000, MSIZE4, 1'b0, '0, 4'h7, acc);
    step();
    set_req(1'b0, 32'h3001, MSIZE4, 1'b0, '0, 4'h8);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mis_ready_blocked", req_ready, 0);
      check("mis_no_dreq", dreq.valid, 0);
      @(posedge clk);
      #1;
    end
    expect_rsp(4'h7, 32'h3333_3333, 1'b0, '0, '0, cyc + 1);
    bus(1'b1, 1'b1, 32'h3333_3333);
    step();
    bus(1'b1, 1'b0, '0);
    offer(1'b0, 32'h3001, MSIZE4, 1'b0, '0, 4'h8, acc);
    expect_rsp(4'h8, 32'h0, 1'b1, EX_ADEL, 32'h3001, acc);
    check("mis_no_dreq_after", dreq.valid, 0);
    step();
    check("mis_no_dreq_later", dreq.valid, 0);
    bus(1'b0, 1'b0, '0);
    step(2);
`else
    // without checking, a misaligned halfword address is forced down to alignment
    offer(1'b0, 32'h3001, MSIZE2, 1'b0, '0, 4'h8, acc);
    check("force_dreq_addr", dreq.addr, 32'h3000);
    expect_rsp(4'h8, 32'h0000_8001, 1'b0, '0, '0, acc + 1);
    bus(1'b1, 1'b1, 32'h5555_8001);
    step();
    bus(1'b0, 1'b0, '0);
    step(2);
`endif

    // no acceptance while flush is high
    flush = 1'b1;
    set_req(1'b0, 32'h7000, MSIZE4, 1'b0, '0, 4'hF);
    @(negedge clk);
    check("flush_blocks_ready", req_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    req_valid = 1'b0;
    step();

    // flush with two outstanding loads: both data_ok consumed silently
    bus(1'b1, 1'b0, '0);
    offer(1'b0, 32'h5000, MSIZE4, 1'b0, '0, 4'h9, acc);
    offer(1'b0, 32'h5004, MSIZE4, 1'b0, '0, 4'hA, acc);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus(1'b1, 1'b1, 32'h9999_9999);
    step(2);
    bus(1'b0, 1'b0, '0);
    step(3);
    offer(1'b0, 32'h5001, MSIZE1, 1'b1, '0, 4'hB, acc);
    expect_rsp(4'hB, 32'hFFFF_FFEE, 1'b0, '0, '0, acc + 1);
    bus(1'b1, 1'b1, 32'h0000_EE00);
    step();
    bus(1'b0, 1'b0, '0);
    step(2);

    // reset with one load outstanding
    bus(1'b1, 1'b0, '0);
    offer(1'b0, 32'h6000, MSIZE4, 1'b0, '0, 4'hC, acc);
    step();
    reset = 1'b1;
    #1;
    check("midreset_dreq_valid", dreq.valid, 0);
    check("midreset_req_ready", req_ready, 0);
    step();
    reset = 1'b0;
    bus(1'b1, 1'b1, 32'h1234_5678);
    step();
    bus(1'b0, 1'b0, '0);
    step(3);
    check("postreset_dreq_valid", dreq.valid, 0);
    offer(1'b0, 32'h6002, MSIZE2, 1'b1, '0, 4'hD, acc);
    expect_rsp(4'hD, 32'hFFFF_8001, 1'b0, '0, '0, acc + 1);
    bus(1'b1, 1'b1, 32'h8001_0000);
    step();
    bus(1'b0, 1'b0, '0);
    step(4);

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
